multicycle_main_fsm: RTL

Main control state machine for the multicycle MIPS datapath. It sequences every instruction through fetch, decode, execute, memory and writeback states, and drives all datapath enables and mux selects. Its 2-bit ALUOp output feeds the existing ALU decoder, which combines ALUOp with Funct to form ALUControl. Memory-handshake stalls are supported via MemReady.

---
 rtl/multicycle_main_fsm.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/
// execute/memory/writeback and drives every datapath enable and mux select.
module multicycle_main_fsm #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       IllegalOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BEQEX    = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JEX      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state;
    state_t next_state;
    logic   pcwrite;
    logic   branch;
    logic   mem_ready;

    // With waiting disabled, memory phases always complete in one cycle.
    assign mem_ready = MEM_WAIT_EN ? MemReady : 1'b1;
    assign State     = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = FETCH;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSrc      = 2'b00;
        IllegalOp  = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;

        case (state)
            FETCH: begin
                ALUSrcB    = 2'b01;
                IRWrite    = mem_ready;
                pcwrite    = mem_ready;
                next_state = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BEQEX;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JEX;
                    default: begin
                        next_state = FETCH;
                        IllegalOp  = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (Op == OP_LW) begin
                    next_state = MEMREAD;
                end else if (Op == OP_SW) begin
                    next_state = MEMWRITE;
                end else begin
                    next_state = FETCH;
                end
            end
            MEMREAD: begin
                IorD       = 1'b1;
                next_state = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWRITE: begin
                // Strobe stays high across the whole wait, not just the completing cycle.
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                next_state = mem_ready ? FETCH : MEMWRITE;
            end
            EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b10;
                next_state = ALUWB;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BEQEX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = ADDIWB;
            end
            ADDIWB: begin
                RegWrite = 1'b1;
            end
            JEX: begin
                PCSrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: begin
                next_state = FETCH;
            end
        endcase

        PCEn = pcwrite | (branch & Zero);
    end

endmodule
